// File: rtl/beat_track_ctrl.sv
// rtl/beat_track_ctrl.sv - beat track recorder/player driving a synchronous single-port RAM
//
// Optional feature macro: BEAT_LOOP_EN (defined: playback loops forever, no DONE state;
// undefined: playback stops after the last recorded slot and holds the last word).
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   resetn     - asynchronous active-low reset
//   record     - record request
//   play       - playback request
//   tick       - one-cycle beat-slot strobe
//   beat_in    - live pad state, written on tick while recording
//   ram_addr   - RAM address (always the slot pointer)
//   ram_wdata  - RAM write data (beat_in)
//   ram_we     - RAM write enable (recording ticks only)
//   ram_rdata  - RAM read data, valid one cycle after ram_addr
//   beat_out   - played-back beat word, held between updates
//   rec_len    - stored track length in slots
//   full       - the last recording filled every slot
module beat_track_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              record,
   input  logic              play,
   input  logic              tick,
   input  logic [DATA_W-1:0] beat_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] beat_out,
   output logic [ADDR_W:0]   rec_len,
   output logic              full
);

`ifdef BEAT_LOOP_EN
   typedef enum logic [1:0] {S_IDLE, S_REC, S_REC_FULL, S_PLAY} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_REC, S_REC_FULL, S_PLAY, S_DONE} state_t;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   len_q;
   logic              full_q;
   logic [DATA_W-1:0] beat_q;
   logic              pend_q;   // a read was issued last cycle; ram_rdata is valid now

   logic [ADDR_W-1:0] ptr_d;
   logic [ADDR_W:0]   len_last;
   logic              last_wr;
   logic              last_rd;

   assign ptr_d    = ptr_q + 1'b1;
   assign len_last = len_q - 1'b1;
   assign last_wr  = (ptr_q == {ADDR_W{1'b1}});
   assign last_rd  = ({1'b0, ptr_q} == len_last);

   // Write strobe follows tick directly; a tick on the cycle record drops is not stored.
   assign ram_we    = (state_q == S_REC) && record && tick;
   assign ram_addr  = ptr_q;
   assign ram_wdata = beat_in;
   assign beat_out  = beat_q;
   assign rec_len   = len_q;
   assign full      = full_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         full_q  <= 1'b0;
         beat_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               pend_q <= 1'b0;
               if (record) begin
                  state_q <= S_REC;
                  ptr_q   <= '0;
                  full_q  <= 1'b0;
               end else if (play) begin
                  state_q <= S_PLAY;
                  ptr_q   <= '0;
               end
            end
            S_REC: begin
               if (!record) begin
                  state_q <= S_IDLE;
                  len_q   <= {1'b0, ptr_q};
               end else if (tick) begin
                  if (last_wr) begin
                     state_q <= S_REC_FULL;
                     full_q  <= 1'b1;
                     len_q   <= {1'b1, {ADDR_W{1'b0}}};
                  end
                  ptr_q <= ptr_d;
               end
            end
            S_REC_FULL: begin
               if (!record) state_q <= S_IDLE;
            end
            S_PLAY: begin
               // Leaving playback drops any read still in flight.
               if (record || !play) begin
                  state_q <= S_IDLE;
                  beat_q  <= '0;
                  pend_q  <= 1'b0;
               end else begin
                  if (pend_q) beat_q <= ram_rdata;
                  pend_q <= 1'b0;
                  if (tick && (len_q != '0)) begin
                     pend_q <= 1'b1;
                     if (last_rd) begin
`ifdef BEAT_LOOP_EN
                        ptr_q <= '0;
`else
                        state_q <= S_DONE;
`endif
                     end else begin
                        ptr_q <= ptr_d;
                     end
                  end
               end
            end
`ifndef BEAT_LOOP_EN
            S_DONE: begin
               // The final read may still be in flight on entry.
               if (record || !play) begin
                  state_q <= S_IDLE;
                  beat_q  <= '0;
                  pend_q  <= 1'b0;
               end else begin
                  if (pend_q) beat_q <= ram_rdata;
                  pend_q <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               pend_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_beat_track_ctrl.sv
// tb/tb_beat_track_ctrl.sv - bench for beat_track_ctrl with RAM, reference model and random traffic
module tb_beat_track_ctrl;
   localparam int AW    = 3;
   localparam int DW    = 4;
   localparam int SLOTS = 1 << AW;
`ifdef BEAT_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   localparam int M_IDLE = 0, M_REC = 1, M_FULL = 2, M_PLAY = 3, M_DONE = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          record = 1'b0;
   logic          play = 1'b0;
   logic          tick = 1'b0;
   logic [DW-1:0] beat_in = '0;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] beat_out;
   logic [AW:0]   rec_len;
   logic          full;

   int total = 0;
   int bad = 0;

   beat_track_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .resetn(resetn), .record(record), .play(play), .tick(tick),
      .beat_in(beat_in), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .beat_out(beat_out), .rec_len(rec_len), .full(full)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM attached to the controller.
   logic [DW-1:0] ram [SLOTS];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: track contents as an array, playback as scheduled deliveries.
   int m_mode = M_IDLE;
   int m_ptr = 0;
   int m_len = 0;
   bit m_full = 1'b0;
   int m_beat = 0;
   int shadow [SLOTS];
   int due_q [$];
   int word_q [$];
   int cyc = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_mode = M_IDLE; m_ptr = 0; m_len = 0; m_full = 1'b0; m_beat = 0;
         due_q.delete(); word_q.delete();
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (record) begin m_mode = M_REC; m_ptr = 0; m_full = 1'b0; end
               else if (play) begin m_mode = M_PLAY; m_ptr = 0; end
            end
            M_REC: begin
               if (!record) begin
                  m_mode = M_IDLE; m_len = m_ptr;
               end else if (tick) begin
                  shadow[m_ptr] = int'(beat_in);
                  if (m_ptr == SLOTS - 1) begin
                     m_mode = M_FULL; m_full = 1'b1; m_len = SLOTS; m_ptr = 0;
                  end else m_ptr++;
               end
            end
            M_FULL: if (!record) m_mode = M_IDLE;
            default: begin
               if (record || !play) begin
                  m_mode = M_IDLE; m_beat = 0;
                  due_q.delete(); word_q.delete();
               end else begin
                  while (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
                     m_beat = word_q[0];
                     void'(due_q.pop_front());
                     void'(word_q.pop_front());
                  end
                  if (m_mode == M_PLAY && tick && m_len > 0) begin
                     due_q.push_back(cyc + 2);
                     word_q.push_back(shadow[m_ptr]);
                     if (m_ptr == m_len - 1) begin
                        if (LOOP) m_ptr = 0;
                        else m_mode = M_DONE;
                     end else m_ptr++;
                  end
               end
            end
         endcase
         cyc++;
      end
   end

   always @(negedge clk) begin
      bit exp_we;
      exp_we = (m_mode == M_REC) && record && tick;
      check("ram_we", int'(ram_we), int'(exp_we));
      if (exp_we) begin
         check("wr_addr", int'(ram_addr), m_ptr);
         check("wr_data", int'(ram_wdata), int'(beat_in));
      end
      if (m_mode == M_PLAY && play && !record && tick && m_len > 0)
         check("rd_addr", int'(ram_addr), m_ptr);
      check("beat_out", int'(beat_out), m_beat);
      check("rec_len", int'(rec_len), m_len);
      check("full", int'(full), int'(m_full));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int we_cnt;
      int expv;
      int prev;

      // Reset state
      repeat (2) step();
      check("rst_beat_out", int'(beat_out), 0);
      check("rst_rec_len", int'(rec_len), 0);
      check("rst_full", int'(full), 0);
      check("rst_ram_we", int'(ram_we), 0);
      resetn = 1'b1;
      step();

      // Record five slots 1..5
      record = 1'b1;
      step();
      for (int i = 1; i <= 5; i++) begin
         beat_in = DW'(i);
         tick = 1'b1;
         #1;
         check("rec5_we", int'(ram_we), 1);
         check("rec5_addr", int'(ram_addr), i - 1);
         step();
         tick = 1'b0;
         step();
      end
      record = 1'b0;
      step();
      check("rec5_len", int'(rec_len), 5);
      check("rec5_full", int'(full), 0);
      for (int i = 0; i < 5; i++) check("rec5_ram", int'(ram[i]), i + 1);

      // Play twelve ticks; each word appears two cycles after its tick
      play = 1'b1;
      step();
      prev = 0;
      for (int k = 0; k < 12; k++) begin
         expv = LOOP ? (k % 5) + 1 : ((k < 5) ? k + 1 : 5);
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("play_early", int'(beat_out), prev);
         step();
         check("play_word", int'(beat_out), expv);
         prev = expv;
      end
      play = 1'b0;
      step();
      check("play_stop_clear", int'(beat_out), 0);
      check("play_len_kept", int'(rec_len), 5);

      // Reset between read tick and data return
      play = 1'b1;
      step();
      tick = 1'b1; step(); tick = 1'b0; step();
      tick = 1'b1; step(); tick = 1'b0;
      check("pre_rst_word", int'(beat_out), 1);
      #2 resetn = 1'b0;
      #1 check("rst_async_beat", int'(beat_out), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      play = 1'b0;
      step();
      step();
      check("rst_no_stale", int'(beat_out), 0);
      check("rst_len", int'(rec_len), 0);

      // Overflow: ten ticks into eight slots
      record = 1'b1;
      step();
      we_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         beat_in = DW'(i);
         tick = 1'b1;
         #1;
         we_cnt += int'(ram_we);
         if (i > 8) check("ovf_no_we", int'(ram_we), 0);
         step();
         tick = 1'b0;
         step();
      end
      check("ovf_wr_count", we_cnt, 8);
      check("ovf_full", int'(full), 1);
      check("ovf_len", int'(rec_len), 8);
      record = 1'b0;
      step();
      check("ovf_full_hold", int'(full), 1);

      // record and play together: record wins
      record = 1'b1; play = 1'b1;
      step();
      tick = 1'b1;
      beat_in = 4'hA;
      #1 check("both_we", int'(ram_we), 1);
      step();
      tick = 1'b0; record = 1'b0; play = 1'b0;
      step();
      check("both_full_clr", int'(full), 0);
      check("both_len", int'(rec_len), 1);

      // Random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 19) == 0) record = ~record;
         if ($urandom_range(0, 14) == 0) play = ~play;
         tick = ($urandom_range(0, 2) == 0);
         beat_in = DW'($urandom);
         resetn = ($urandom_range(0, 599) != 0);
         step();
      end
      resetn = 1'b1;
      record = 1'b0; play = 1'b0; tick = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/beat_track_ctrl.md
BEAT_TRACK_CTRL -- requirements
Module: beat_track_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: track RAM address width, giving 2^ADDR_W beat slots.
REQ-002 SHALL have parameter DATA_W, default 4: beat word width, one bit per drum pad.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port record, input, 1: record request (driven by FSM ramARecord/ramBRecord).
REQ-006 SHALL have port play, input, 1: playback request (driven by FSM loadAFromRam/loadBFromRam).
REQ-007 SHALL have port tick, input, 1: one-cycle beat-slot strobe.
REQ-008 SHALL have port beat_in, input, DATA_W: live pad state, sampled on tick while recording.
REQ-009 SHALL have ports ram_addr (ADDR_W), ram_wdata (DATA_W) and ram_we (1), all outputs: synchronous single-port RAM write side.
REQ-010 SHALL have port ram_rdata, input, DATA_W: RAM read data, valid one cycle after ram_addr is presented.
REQ-011 SHALL have port beat_out, output, DATA_W: played-back beat word, held between updates.
REQ-012 SHALL have ports rec_len (output, ADDR_W+1, stored length in slots) and full (output, 1, track overflowed).

Function
REQ-013 SHALL implement the states IDLE, REC, REC_FULL, PLAY and, only when BEAT_LOOP_EN is undefined, DONE.
REQ-014 From IDLE: record=1 -> REC, with the pointer set to 0 and full cleared; else play=1 -> PLAY, with the pointer set to 0; record has priority when both are 1.
REQ-015 In REC: ram_we = tick, combinational; ram_addr = pointer; ram_wdata = beat_in; the pointer increments on every tick.
REQ-016 A tick that writes the last address (2^ADDR_W-1) -> REC_FULL; full=1; rec_len=2^ADDR_W; no further writes.
REQ-017 REC with record=0 -> IDLE, with rec_len = pointer on the same edge; a tick in that same cycle is not written.
REQ-018 REC_FULL with record=0 -> IDLE; full stays 1 until the next REC entry or reset.
REQ-019 In PLAY with rec_len>0: on tick, ram_addr = pointer and the pointer advances; the pointer wraps to 0 after address rec_len-1.
REQ-020 beat_out SHALL load ram_rdata on the edge ending the cycle after the read tick: visible 2 cycles after tick.
REQ-021 In PLAY with rec_len=0: no reads are issued and beat_out=0.
REQ-022 play=0 in PLAY or DONE -> IDLE; beat_out SHALL clear to 0 on that edge and a pending read SHALL be discarded.
REQ-023 ram_we SHALL be 0 in every state other than REC.
REQ-024 record=1 while in PLAY or DONE -> IDLE, then REC next cycle; playback is abandoned.
REQ-025 ram_addr SHALL hold the pointer value in all states; rec_len is unchanged by playback.

Reset
REQ-026 resetn=0 SHALL asynchronously force: state IDLE, pointer 0, rec_len 0, full 0, beat_out 0, ram_we 0, pending-read flag 0.
REQ-027 Reset mid-REC SHALL discard the partial take (rec_len=0).

Configuration
REQ-028 Macro BEAT_LOOP_EN defined: playback loops indefinitely per REQ-019; the DONE state is absent.
REQ-029 BEAT_LOOP_EN undefined: after the read of address rec_len-1 -> DONE. beat_out keeps the last word until play=0, then clears. No wrap.

Verification
REQ-030 Reset then record=1 for 5 ticks with beat_in=1,2,3,4,5 -> writes at addr 0..4 with matching data; record=0 -> rec_len=5, full=0.
REQ-031 Play with rec_len=5 and loop enabled, 12 ticks -> beat_out sequence 1,2,3,4,5,1,2,3,4,5,1,2, each appearing 2 cycles after its tick.
REQ-032 ADDR_W=3, record for 10 ticks -> 8 writes, full=1, rec_len=8, ram_we=0 on ticks 9-10.
REQ-033 record=1 and play=1 asserted together from IDLE -> REC entered, ram_we pulses on tick.
REQ-034 Loop disabled, rec_len=3, play for 6 ticks -> reads at addr 0,1,2 only; beat_out holds word 3; play=0 -> beat_out=0.
REQ-035 resetn pulsed low mid-PLAY between tick and data return -> beat_out=0 immediately; no stale update afterwards.
